morse_receiver: RTL
===================

Name: morse_receiver

Overview:
- Decodes hand-keyed Morse code back into a 3-bit letter code (J..Q), the reverse of the letter-to-LED Morse display block.
- Times each key-down interval and classifies it as a dot or a dash; times key-up gaps to find symbol and letter boundaries.
- Sits between a debounced push-button input and the letter consumer (LED/HEX display or a loopback checker against the Morse transmitter).

Parameters:
- CLK_PER_UNIT, 25000000: CLOCK_50 cycles per Morse time unit (0.5 s); must be >= 2.
- DASH_UNITS, 2: a mark lasting >= this many complete units is a dash; shorter is a dot.
- GAP_UNITS, 3: a key-up gap of this many units ends the letter; range 1..7.

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- key_in  input  1  Morse key level, 1 = key down; debounced upstream.
- letter  output  3  decoded letter: J=0, K=1, L=2, M=3, N=4, O=5, P=6, Q=7; held until the next valid letter.
- letter_valid  output  1  one-cycle pulse when letter is updated.
- letter_err  output  1  one-cycle pulse when an unrecognised or overlong sequence ends.
- busy  output  1  high while a letter is being received (state != IDLE).
- key_led  output  1  registered copy of key_in, for LEDR feedback.

Behaviour:
- Reset (async, resetn=0): state IDLE; letter=0, letter_valid=0, letter_err=0, busy=0, key_led=0; prescaler, unit count, symbol register and symbol count all cleared.
- Unit tick: the prescaler counts 0..CLK_PER_UNIT-1 and pulses tick on terminal count.
  - It restarts at 0 on every state transition.
  - It is held at 0 in IDLE.
- Unit count: 3 bits, incremented on tick, saturates at 7, cleared on every state transition.
- FSM states: IDLE, MARK, SPACE, DONE.
- IDLE: key_in=1 -> MARK.
- MARK: on the first cycle key_in=0, classify the mark:
  - dash if unit count >= DASH_UNITS, else dot (a 0-unit glitch counts as a dot);
  - write the symbol to sym[sym_cnt] (index 0 = first symbol; 1 = dash);
  - if sym_cnt is already 4, set the overflow flag instead of writing; sym_cnt saturates at 4 with overflow set;
  - go to SPACE.
- SPACE:
  - key_in=1 before the gap completes -> MARK (next symbol of the same letter).
  - Gap completes (tick with unit count == GAP_UNITS-1) -> DONE.
  - If key_in rises in the same cycle the gap completes, gap completion wins; the press is picked up from IDLE.
- DONE (one cycle): match (sym_cnt, sym) against the table:
  - J .--- ; K -.- ; L .-.. ; M -- ; N -. ; O --- ; P .--. ; Q --.-
  - On a match: latch letter and pulse letter_valid.
  - On no match or overflow: pulse letter_err; letter is unchanged.
  - Always: clear sym, sym_cnt and overflow; go to IDLE.
- Latency: if key_in is first sampled low at cycle r, the pulse appears at cycle r + GAP_UNITS*CLK_PER_UNIT + 1.
- letter_valid and letter_err are never high together; each is high for exactly one cycle.
- A key held indefinitely stays in MARK; the count saturates and the mark classifies as a dash.
- Reset asserted mid-letter aborts the letter with no pulse.

Optional Feature:
- Macro: MORSE_RX_SYNC_EN.
- Defined: key_in passes through a 2-flop synchroniser (reset to 0) before the FSM and key_led. Every timing point above shifts 2 cycles later.
- Undefined: key_in is sampled directly; it must already be synchronous to CLOCK_50.

Decomposition:
- Shared package morse_pkg holds:
  - FSM state encoding;
  - letter codes J..Q (shared with the Morse transmitter);
  - per-letter symbol length and pattern constants, which the decode table uses;
  - MAX_SYMBOLS=4.
- One natural sub-module: morse_unit_timer (prescaler + saturating unit counter with clear input, tick and count outputs).

Test Plan (bench uses CLK_PER_UNIT=4, DASH_UNITS=2, GAP_UNITS=3; U = 4 cycles):
- K: key down 8 cycles, up 4, down 4, up 4, down 8, then up -> letter=1, letter_valid pulses exactly 13 cycles after the last release, busy falls the cycle after.
- M: two 12-cycle marks separated by a 4-cycle space -> letter=3; a 1-cycle glitch mark followed by a 20-cycle gap -> letter_err pulse, letter still 3.
- Overflow: 5 dots, each 4 down / 4 up -> letter_err pulse, no letter_valid.
- Gap boundary: a 4-cycle mark, then 11 cycles up, then another 4-cycle mark -> the same letter continues (no pulse yet); the gap then ends after a second 4-cycle mark with exactly 12 cycles up -> error pulse for '..' (sequence unrecognised).
- Reset mid-letter: assert resetn=0 during SPACE of a P sequence -> all outputs 0, no pulse. After release, a full O sequence -> letter=5.
- MORSE_RX_SYNC_EN build: repeat the K test -> the pulse occurs 2 cycles later than without the macro.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM encoding, letter codes J..Q and the symbol table.
// Symbol patterns store the first symbol in bit 0; 1 = dash, 0 = dot.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2,
      ST_DONE  = 2'd3
   } morse_state_e;

   localparam int MAX_SYMBOLS = 4;

   localparam logic [2:0] LTR_J = 3'd0;
   localparam logic [2:0] LTR_K = 3'd1;
   localparam logic [2:0] LTR_L = 3'd2;
   localparam logic [2:0] LTR_M = 3'd3;
   localparam logic [2:0] LTR_N = 3'd4;
   localparam logic [2:0] LTR_O = 3'd5;
   localparam logic [2:0] LTR_P = 3'd6;
   localparam logic [2:0] LTR_Q = 3'd7;

   localparam logic [2:0] LEN_J = 3'd4;
   localparam logic [2:0] LEN_K = 3'd3;
   localparam logic [2:0] LEN_L = 3'd4;
   localparam logic [2:0] LEN_M = 3'd2;
   localparam logic [2:0] LEN_N = 3'd2;
   localparam logic [2:0] LEN_O = 3'd3;
   localparam logic [2:0] LEN_P = 3'd4;
   localparam logic [2:0] LEN_Q = 3'd4;

   // Unused high bits stay zero, so a pattern compares directly against sym.
   localparam logic [3:0] PAT_J = 4'b1110;  // .---
   localparam logic [3:0] PAT_K = 4'b0101;  // -.-
   localparam logic [3:0] PAT_L = 4'b0010;  // .-..
   localparam logic [3:0] PAT_M = 4'b0011;  // --
   localparam logic [3:0] PAT_N = 4'b0001;  // -.
   localparam logic [3:0] PAT_O = 4'b0111;  // ---
   localparam logic [3:0] PAT_P = 4'b0110;  // .--.
   localparam logic [3:0] PAT_Q = 4'b1011;  // --.-

   typedef struct packed {
      logic       hit;
      logic [2:0] code;
   } morse_match_t;

   function automatic morse_match_t match_symbols(input logic [2:0] cnt,
                                                  input logic [3:0] sym);
      morse_match_t m;
      m.hit  = 1'b1;
      m.code = 3'd0;
      case ({cnt, sym})
         {LEN_J, PAT_J}: m.code = LTR_J;
         {LEN_K, PAT_K}: m.code = LTR_K;
         {LEN_L, PAT_L}: m.code = LTR_L;
         {LEN_M, PAT_M}: m.code = LTR_M;
         {LEN_N, PAT_N}: m.code = LTR_N;
         {LEN_O, PAT_O}: m.code = LTR_O;
         {LEN_P, PAT_P}: m.code = LTR_P;
         {LEN_Q, PAT_Q}: m.code = LTR_Q;
         default:        m.hit  = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: prescaler producing a tick every CLK_PER_UNIT cycles plus a
// 3-bit saturating unit count. Both reset to zero on clear_i or while run_i is low.
module morse_unit_timer #(
   parameter int CLK_PER_UNIT = 25000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       run_i,
   input  logic       clear_i,
   output logic       tick_o,
   output logic [2:0] units_o
);

   localparam int            CW   = $clog2(CLK_PER_UNIT);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_UNIT - 1);

   logic [CW-1:0] pre_q, pre_d;
   logic [2:0]    units_q, units_d;

   assign tick_o  = run_i && (pre_q == LAST);
   assign units_o = units_q;

   always_comb begin
      pre_d   = pre_q;
      units_d = units_q;
      if (clear_i || !run_i) begin
         pre_d   = '0;
         units_d = '0;
      end else if (tick_o) begin
         pre_d = '0;
         if (units_q != 3'd7) begin
            units_d = units_q + 3'd1;
         end
      end else begin
         pre_d = pre_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q   <= '0;
         units_q <= '0;
      end else begin
         pre_q   <= pre_d;
         units_q <= units_d;
      end
   end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: times key-down marks and key-up gaps and decodes letters J..Q.
// Optional MORSE_RX_SYNC_EN adds a 2-flop synchroniser on key_in.
module morse_receiver
   import morse_pkg::*;
#(
   parameter int CLK_PER_UNIT = 25000000,
   parameter int DASH_UNITS   = 2,
   parameter int GAP_UNITS    = 3
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       key_in,
   output logic [2:0] letter,
   output logic       letter_valid,
   output logic       letter_err,
   output logic       busy,
   output logic       key_led
);

   localparam logic [3:0] DASH_L   = 4'(DASH_UNITS);
   localparam logic [2:0] GAP_LAST = 3'(GAP_UNITS - 1);

   logic key_s;
   logic key_led_q;

`ifdef MORSE_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], key_in};
      end
   end

   assign key_s = sync_q[1];
`else
   assign key_s = key_in;
`endif

   morse_state_e state_q, state_d;
   logic [3:0]   sym_q, sym_d;
   logic [2:0]   sym_cnt_q, sym_cnt_d;
   logic         ovf_q, ovf_d;
   logic [2:0]   letter_q, letter_d;
   logic         valid_q, valid_d;
   logic         err_q, err_d;

   logic         tick;
   logic [2:0]   units;
   logic         timer_clear;
   logic [3:0]   mark_units;
   logic         is_dash;
   logic         gap_done;
   morse_match_t match;

   assign timer_clear = (state_d != state_q);

   morse_unit_timer #(
      .CLK_PER_UNIT(CLK_PER_UNIT)
   ) u_timer (
      .clk_i  (CLOCK_50),
      .rst_ni (resetn),
      .run_i  (state_q != ST_IDLE),
      .clear_i(timer_clear),
      .tick_o (tick),
      .units_o(units)
   );

   // A unit completing on the release cycle still counts towards the mark,
   // so an N-unit key-down classifies as N units despite the IDLE entry cycle.
   assign mark_units = {1'b0, units} + {3'b000, tick};
   assign is_dash    = (mark_units >= DASH_L);
   assign gap_done   = tick && (units == GAP_LAST);
   assign match      = match_symbols(sym_cnt_q, sym_q);

   always_comb begin
      state_d   = state_q;
      sym_d     = sym_q;
      sym_cnt_d = sym_cnt_q;
      ovf_d     = ovf_q;
      letter_d  = letter_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (key_s) begin
               state_d = ST_MARK;
            end
         end
         ST_MARK: begin
            if (!key_s) begin
               if (sym_cnt_q == 3'(MAX_SYMBOLS)) begin
                  ovf_d = 1'b1;
               end else begin
                  sym_d[sym_cnt_q[1:0]] = is_dash;
                  sym_cnt_d             = sym_cnt_q + 3'd1;
               end
               state_d = ST_SPACE;
            end
         end
         ST_SPACE: begin
            // Gap completion outranks a same-cycle press; IDLE picks the press up.
            if (gap_done) begin
               if (match.hit && !ovf_q) begin
                  letter_d = match.code;
                  valid_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_DONE;
            end else if (key_s) begin
               state_d = ST_MARK;
            end
         end
         ST_DONE: begin
            sym_d     = '0;
            sym_cnt_d = '0;
            ovf_d     = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         sym_q     <= '0;
         sym_cnt_q <= '0;
         ovf_q     <= 1'b0;
         letter_q  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         key_led_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_q     <= sym_d;
         sym_cnt_q <= sym_cnt_d;
         ovf_q     <= ovf_d;
         letter_q  <= letter_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         key_led_q <= key_s;
      end
   end

   assign letter       = letter_q;
   assign letter_valid = valid_q;
   assign letter_err   = err_q;
   assign busy         = (state_q != ST_IDLE);
   assign key_led      = key_led_q;

endmodule
